dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one single-ported data memory between NUM_CORES pipeline cores in the multicore build.
- Sits between each core's MEM stage (address, store data, read/write, half/byte controls) and the shared data memory.
- Serialises accesses, returns load data and a per-core done pulse, and generates per-core stall so each core holds its pipeline until its access completes.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 32, memory address width
DATA_W, 32, data width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
core_req  in  NUM_CORES  access request per core; held high until that core's done
core_we  in  NUM_CORES  1 = store, 0 = load
core_half  in  NUM_CORES  halfword access
core_byte  in  NUM_CORES  byte access
core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_CORES*DATA_W  packed store data
core_rdata  out  DATA_W  load data, shared by all cores; qualified by core_done
core_done  out  NUM_CORES  one-hot, one-cycle completion pulse
core_stall  out  NUM_CORES  core_req & ~core_done
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_half  out  1  halfword control to memory
mem_byte  out  1  byte control to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: one clock Clk; Reset is synchronous, active-high.
- Reset values:
  - State = IDLE, grant = 0, last = NUM_CORES-1, so core 0 has first priority.
  - All mem_* outputs = 0; core_done = 0; core_rdata = 0.
- FSM: three states.
  - IDLE: when any eligible req is present, pick a winner g, latch that core's we/half/byte/addr/wdata into command registers, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_en = 1 and mem_* are driven from the command registers. Always go to RESP.
  - RESP (1 cycle): core_done[g] = 1. For loads, core_rdata = mem_rdata, passed through combinationally; for stores, core_rdata = 0. Arbitrate again this cycle with core g masked out. If a winner exists, latch it and go to ISSUE; otherwise go to IDLE.
- Outside ISSUE, mem_en and mem_we are 0, and mem_addr, mem_wdata, mem_half and mem_byte are 0.
- Arbitration:
  - Round robin: search from index last+1 upward, wrapping modulo NUM_CORES. The first set, eligible req wins.
  - last <= g at each grant.
  - Eligible = core_req, excluding the core being done in the current cycle.
- Latency: req rises in IDLE at cycle t → ISSUE at t+1 → done at t+2. Back-to-back service gives one access per 2 cycles.
- Stall: core_stall[i] = core_req[i] & ~core_done[i], combinational. A core with req low is never stalled.
- Boundary conditions:
  - Simultaneous requests are served in rotating order. With all NUM_CORES requesting continuously, each core is served exactly once per NUM_CORES grants; no starvation.
  - Req dropped before grant: ignored, no done pulse.
  - Req dropped after grant: the access still completes and done still pulses, because the command is already latched.
  - Command fields are sampled only at grant; later changes do not affect the access in flight.
  - core_half and core_byte both high: passed through unmodified.
  - Reset asserted in ISSUE or RESP: next state IDLE and all outputs return to reset values. The in-flight access gets no done pulse, and the core must re-request.
  - At most one core_done bit is high in any cycle; at most one access is outstanding.

Test Plan:
- Single load: core 1 req, addr 0x10, mem_rdata = 0xDEADBEEF → mem_en at t+1 with mem_addr = 0x10 and mem_we = 0; core_done = 0b0010 at t+2; core_rdata = 0xDEADBEEF; core_stall[1] = 1 at t and t+1, 0 at t+2.
- Store with half: core 2 we = 1, half = 1, addr 0x22, wdata 0x1234 → at t+1 mem_en = mem_we = mem_half = 1, mem_addr = 0x22, mem_wdata = 0x1234; done[2] at t+2.
- Contention: all four cores request continuously from reset → grant order 0,1,2,3,0; done pulses every 2 cycles at t+2, t+4, t+6, t+8, t+10.
- Mask on done: core 0 keeps req high one cycle after its done while core 3 is waiting → core 3 is granted next, not core 0 again.
- Reset mid-op: Reset asserted during ISSUE of core 2's access → next cycle IDLE, mem_en = 0, no done pulse for core 2; after release, core 0 wins a tie against core 2.
- Field change after grant: core 1 changes addr from 0x40 to 0x80 during ISSUE → mem_addr stays 0x40.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-ported data
// memory between NUM_CORES cores, one access every two cycles.
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_half,
  input  logic [NUM_CORES-1:0]        core_byte,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_stall,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic                        mem_half,
  output logic                        mem_byte,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IW = $clog2(NUM_CORES);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic              half;
    logic              bsel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t                 state;
  state_t                 nxt;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          last;
  cmd_t                   cmd;
  logic [NUM_CORES-1:0]   elig;
  logic [IW-1:0]          win;
  logic                   found;
  logic                   arb_on;
  logic                   take;

  // Arbitration happens in IDLE and again in RESP for back-to-back service.
  assign arb_on = (state == IDLE) || (state == RESP);
  assign take   = arb_on & found;

  // The core finishing this cycle is masked so others get a turn.
  assign elig = core_req & ~core_done;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!found && elig[(int'(last) + k) % NUM_CORES]) begin
        win   = IW'((int'(last) + k) % NUM_CORES);
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = found ? ISSUE : IDLE;
      ISSUE:   nxt = RESP;
      RESP:    nxt = found ? ISSUE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Capture the winner and its command at grant time only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant <= '0;
      last  <= LAST_RST;
      cmd   <= '0;
    end else if (take) begin
      grant     <= win;
      last      <= win;
      cmd.we    <= core_we[win];
      cmd.half  <= core_half[win];
      cmd.bsel  <= core_byte[win];
      cmd.addr  <= core_addr[int'(win)*ADDR_W +: ADDR_W];
      cmd.wdata <= core_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  // Memory strobes in ISSUE, completion and load data in RESP.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_half   = 1'b0;
    mem_byte   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_done  = '0;
    core_rdata = '0;
    case (state)
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = cmd.we;
        mem_half  = cmd.half;
        mem_byte  = cmd.bsel;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;
      end
      RESP: begin
        core_done[grant] = 1'b1;
        core_rdata = cmd.we ? '0 : mem_rdata;
      end
      default: begin
      end
    endcase
  end

  assign core_stall = core_req & ~core_done;

endmodule
